csr_regfile: RTL and testbench
==============================

Name: csr_regfile

Overview:
- Machine-mode CSR register file; the responder end of the execute-stage CSR write interface (csr_we/csr_waddr/csr_wdata).
- Supplies combinational read data for CSR instructions.
- Holds 64-bit cycle and instret counters.
- Takes trap entry and mret updates from the commit/interrupt logic.
- Exports mtvec, mepc and interrupt-enable state to the fetch and interrupt units.

Parameters:
- DW, 32, CSR data width; only 32 is supported.
- AW, 32, CSR address port width; only bits [11:0] are decoded.
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, constant returned by mhartid.
- MISA_VAL, 32'h4000_0100, constant returned by misa (RV32I).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- csr_we_i  in  1  CSR write enable from execute
- csr_waddr_i  in  AW  CSR write address
- csr_wdata_i  in  DW  CSR write data (final value; set/clear already resolved upstream)
- csr_raddr_i  in  AW  CSR read address
- csr_rdata_o  out  DW  read data, combinational
- csr_illegal_o  out  1  csr_raddr_i not implemented
- inst_retire_i  in  1  one instruction retired this cycle
- irq_pending_i  in  3  {MEIP,MTIP,MSIP} mirrored into mip
- trap_i  in  1  trap entry strobe
- trap_cause_i  in  DW  mcause value
- trap_pc_i  in  DW  mepc value
- trap_val_i  in  DW  mtval value
- mret_i  in  1  mret commit strobe
- mtvec_o  out  DW  trap vector
- mepc_o  out  DW  return PC
- mstatus_mie_o  out  1  global interrupt enable
- mie_o  out  3  {MEIE,MTIE,MSIE}

Behaviour:
- Implemented CSRs and writable fields:
  - mstatus 0x300: MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: read-only.
  - mie 0x304: bits 3, 7, 11 writable.
  - mtvec 0x305: [1:0] forced 0.
  - mscratch 0x340: fully writable.
  - mepc 0x341: [1:0] forced 0.
  - mcause 0x342, mtval 0x343: fully writable.
  - mip 0x344: read-only, {irq[2] at 11, irq[1] at 7, irq[0] at 3}.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: writable halves.
  - cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82: read-only shadows.
  - mhartid 0xF14: read-only.
- Writes to read-only or unimplemented addresses are silently dropped.
- Reset values: every register 0 except mtvec=MTVEC_RST. All outputs therefore reset to 0, except mtvec_o=MTVEC_RST.
- Read path: zero latency, from current register state. An unimplemented address returns 0 with csr_illegal_o=1.
- Read-during-write to the same address returns the old value; the new value is visible the next cycle.
- Write latency: one cycle; the new value is visible at the clock edge after csr_we_i is sampled.
- mcycle: increments every cycle, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A write to the low half loads {hi, wdata} with no increment that cycle.
  - A write to the high half loads {wdata, lo} with no increment.
- minstret: increments when inst_retire_i=1, with the same half-write rule. A CSR write beats the increment in the same cycle.
- Trap entry (trap_i=1): mepc<=trap_pc_i&~3, mcause<=trap_cause_i, mtval<=trap_val_i, MPIE<=MIE, MIE<=0.
- mret (mret_i=1, trap_i=0): MIE<=MPIE, MPIE<=1.
- Priority per register: trap_i > mret_i > csr write. Lower-priority writes to the same register in that cycle are dropped; writes to unaffected CSRs in the same cycle still occur.
- Reset asserted mid-operation returns all state to reset values asynchronously; counters restart from 0 after deassertion.

Decomposition:
- Package alioth_csr_pkg holds:
  - 12-bit CSR address localparams;
  - mstatus/mie/mip bit-position constants;
  - a typedef for the mstatus field struct;
  - reset constants.
- One sub-module, csr_counter64: 64-bit counter with inc_i, lo_we_i, hi_we_i, wdata_i, cnt_o. It is instantiated twice, for mcycle and minstret.

Test Plan:
- Reset, then read 0x305 -> MTVEC_RST; read 0xB00 after 5 idle cycles -> 5; read 0x7C0 -> 0 with csr_illegal_o=1.
- Write 0x341=0x8000_0123; next-cycle read -> 0x8000_0120. Same-cycle read of 0x341 returns the previous value.
- Write mcycle low=0xFFFF_FFFF with high=0; two cycles later mcycleh=1 and mcycle=0 (wrap carry, no increment on the write cycle).
- Write mstatus=0x8 (MIE=1), then trap_i with pc=0x100, cause=0x8000_000B: mepc=0x100, mcause=0x8000_000B, MIE=0, MPIE=1. Then mret_i: MIE=1, MPIE=1.
- trap_i and a CSR write to 0x342=0x5 in the same cycle: mcause takes the trap value. A write to 0x340=0xA5 in that cycle still lands.
- inst_retire_i held for 3 cycles with a minstret write of 0x10 in the 2nd cycle: final minstret=0x11. A write of 0x1234 to 0xC00 is ignored.

Source files
------------

// File: rtl/csr_regfile_pkg.sv
// Shared CSR addresses, field positions, reset constants and packing helpers
// for the machine-mode CSR register file.
package alioth_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LSB  = 11;

    localparam int unsigned IRQ_MSI_BIT = 3;
    localparam int unsigned IRQ_MTI_BIT = 7;
    localparam int unsigned IRQ_MEI_BIT = 11;

    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

    localparam mstatus_t    MSTATUS_RST = '0;
    localparam logic [63:0] CNT_RST     = '0;

    // MPP is hardwired to M-mode since only machine mode exists.
    function automatic logic [31:0] mstatus_to_csr(mstatus_t s);
        logic [31:0] r;
        r = '0;
        r[MSTATUS_MPP_LSB +: 2] = 2'b11;
        r[MSTATUS_MPIE_BIT]     = s.mpie;
        r[MSTATUS_MIE_BIT]      = s.mie;
        return r;
    endfunction

    function automatic logic [31:0] irq3_to_csr(logic [2:0] b);
        logic [31:0] r;
        r = '0;
        r[IRQ_MEI_BIT] = b[2];
        r[IRQ_MTI_BIT] = b[1];
        r[IRQ_MSI_BIT] = b[0];
        return r;
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// CSR access channel between execute (master) and the CSR register file (slave).
interface csr_regfile_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic          csr_we_i;
    logic [AW-1:0] csr_waddr_i;
    logic [DW-1:0] csr_wdata_i;
    logic [AW-1:0] csr_raddr_i;
    logic [DW-1:0] csr_rdata_o;
    logic          csr_illegal_o;

    modport master (
        output csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
        input  csr_rdata_o, csr_illegal_o
    );

    modport slave (
        input  csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
        output csr_rdata_o, csr_illegal_o
    );
endinterface

// File: rtl/csr_regfile_counter64.sv
// 64-bit free-running counter with independently loadable 32-bit halves;
// a half-load takes the place of the increment in that cycle.
module csr_counter64
    import alioth_csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        lo_we_i,
    input  logic        hi_we_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] cnt_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_o <= CNT_RST;
        end else if (lo_we_i) begin
            cnt_o <= {cnt_o[63:32], wdata_i};
        end else if (hi_we_i) begin
            cnt_o <= {wdata_i, cnt_o[31:0]};
        end else if (inc_i) begin
            cnt_o <= cnt_o + 64'd1;
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: zero-latency reads, one-cycle writes,
// trap/mret updates taking priority over execute-stage writes.
module csr_regfile
    import alioth_csr_pkg::*;
#(
    parameter int unsigned   DW        = 32,
    parameter int unsigned   AW        = 32,
    parameter logic [DW-1:0] MTVEC_RST = 32'h0000_0000,
    parameter int unsigned   HART_ID   = 0,
    parameter logic [DW-1:0] MISA_VAL  = 32'h4000_0100
) (
    input  logic          clk,
    input  logic          rst,
    csr_regfile_if.slave  csr,
    input  logic          inst_retire_i,
    input  logic [2:0]    irq_pending_i,
    input  logic          trap_i,
    input  logic [DW-1:0] trap_cause_i,
    input  logic [DW-1:0] trap_pc_i,
    input  logic [DW-1:0] trap_val_i,
    input  logic          mret_i,
    output logic [DW-1:0] mtvec_o,
    output logic [DW-1:0] mepc_o,
    output logic          mstatus_mie_o,
    output logic [2:0]    mie_o
);

    logic [11:0]   waddr;
    logic [11:0]   raddr;
    logic [DW-1:0] wdata;
    logic          unused_addr_hi;

    assign waddr          = csr.csr_waddr_i[11:0];
    assign raddr          = csr.csr_raddr_i[11:0];
    assign wdata          = csr.csr_wdata_i;
    assign unused_addr_hi = ^{csr.csr_waddr_i[AW-1:12], csr.csr_raddr_i[AW-1:12]};

    logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause, we_mtval;
    logic we_mcycle, we_mcycleh, we_minstret, we_minstreth;

    assign we_mstatus   = csr.csr_we_i && (waddr == CSR_MSTATUS);
    assign we_mie       = csr.csr_we_i && (waddr == CSR_MIE);
    assign we_mtvec     = csr.csr_we_i && (waddr == CSR_MTVEC);
    assign we_mscratch  = csr.csr_we_i && (waddr == CSR_MSCRATCH);
    assign we_mepc      = csr.csr_we_i && (waddr == CSR_MEPC);
    assign we_mcause    = csr.csr_we_i && (waddr == CSR_MCAUSE);
    assign we_mtval     = csr.csr_we_i && (waddr == CSR_MTVAL);
    assign we_mcycle    = csr.csr_we_i && (waddr == CSR_MCYCLE);
    assign we_mcycleh   = csr.csr_we_i && (waddr == CSR_MCYCLEH);
    assign we_minstret  = csr.csr_we_i && (waddr == CSR_MINSTRET);
    assign we_minstreth = csr.csr_we_i && (waddr == CSR_MINSTRETH);

    mstatus_t      mstatus_q;
    logic [2:0]    mie_q;
    logic [DW-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0]   mcycle_q, minstret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q <= MSTATUS_RST;
        end else if (trap_i) begin
            mstatus_q.mpie <= mstatus_q.mie;
            mstatus_q.mie  <= 1'b0;
        end else if (mret_i) begin
            mstatus_q.mie  <= mstatus_q.mpie;
            mstatus_q.mpie <= 1'b1;
        end else if (we_mstatus) begin
            mstatus_q.mie  <= wdata[MSTATUS_MIE_BIT];
            mstatus_q.mpie <= wdata[MSTATUS_MPIE_BIT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
        end else begin
            if (we_mie)      mie_q      <= {wdata[IRQ_MEI_BIT], wdata[IRQ_MTI_BIT], wdata[IRQ_MSI_BIT]};
            if (we_mtvec)    mtvec_q    <= {wdata[DW-1:2], 2'b00};
            if (we_mscratch) mscratch_q <= wdata;
        end
    end

    // Trap entry owns mepc/mcause/mtval for the cycle; execute writes to them are lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else if (trap_i) begin
            mepc_q   <= {trap_pc_i[DW-1:2], 2'b00};
            mcause_q <= trap_cause_i;
            mtval_q  <= trap_val_i;
        end else begin
            if (we_mepc)   mepc_q   <= {wdata[DW-1:2], 2'b00};
            if (we_mcause) mcause_q <= wdata;
            if (we_mtval)  mtval_q  <= wdata;
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .lo_we_i (we_mcycle),
        .hi_we_i (we_mcycleh),
        .wdata_i (wdata),
        .cnt_o   (mcycle_q)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (inst_retire_i),
        .lo_we_i (we_minstret),
        .hi_we_i (we_minstreth),
        .wdata_i (wdata),
        .cnt_o   (minstret_q)
    );

    logic [DW-1:0] rdata;
    logic          illegal;

    always_comb begin
        rdata   = '0;
        illegal = 1'b0;
        case (raddr)
            CSR_MSTATUS:                  rdata = mstatus_to_csr(mstatus_q);
            CSR_MISA:                     rdata = MISA_VAL;
            CSR_MIE:                      rdata = irq3_to_csr(mie_q);
            CSR_MTVEC:                    rdata = mtvec_q;
            CSR_MSCRATCH:                 rdata = mscratch_q;
            CSR_MEPC:                     rdata = mepc_q;
            CSR_MCAUSE:                   rdata = mcause_q;
            CSR_MTVAL:                    rdata = mtval_q;
            CSR_MIP:                      rdata = irq3_to_csr(irq_pending_i);
            CSR_MCYCLE, CSR_CYCLE:        rdata = mcycle_q[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:      rdata = mcycle_q[63:32];
            CSR_MINSTRET, CSR_INSTRET:    rdata = minstret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  rdata = minstret_q[63:32];
            CSR_MHARTID:                  rdata = DW'(HART_ID);
            default:                      illegal = 1'b1;
        endcase
    end

    assign csr.csr_rdata_o   = rdata;
    assign csr.csr_illegal_o = illegal;

    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign mstatus_mie_o = mstatus_q.mie;
    assign mie_o         = mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed vector table, hand sequences
// for reset behaviour, and randomized traffic against a behavioural model.
module tb_csr_regfile;

    localparam logic [31:0] TB_MTVEC_RST = 32'h0000_1000;
    localparam int unsigned TB_HART_ID   = 3;
    localparam logic [31:0] TB_MISA      = 32'h4000_0100;

    logic        clk;
    logic        rst;
    logic        inst_retire_i;
    logic [2:0]  irq_pending_i;
    logic        trap_i;
    logic [31:0] trap_cause_i, trap_pc_i, trap_val_i;
    logic        mret_i;
    logic [31:0] mtvec_o, mepc_o;
    logic        mstatus_mie_o;
    logic [2:0]  mie_o;

    csr_regfile_if #(.DW(32), .AW(32)) bus ();

    csr_regfile #(
        .MTVEC_RST (TB_MTVEC_RST),
        .HART_ID   (TB_HART_ID)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .csr           (bus),
        .inst_retire_i (inst_retire_i),
        .irq_pending_i (irq_pending_i),
        .trap_i        (trap_i),
        .trap_cause_i  (trap_cause_i),
        .trap_pc_i     (trap_pc_i),
        .trap_val_i    (trap_val_i),
        .mret_i        (mret_i),
        .mtvec_o       (mtvec_o),
        .mepc_o        (mepc_o),
        .mstatus_mie_o (mstatus_mie_o),
        .mie_o         (mie_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        mie, mpie;
        logic [2:0]  ie;
        logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
        logic [63:0] cyc, ins;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t s;
        s.mie = 0; s.mpie = 0; s.ie = 0;
        s.mtvec = TB_MTVEC_RST; s.mscratch = 0; s.mepc = 0; s.mcause = 0; s.mtval = 0;
        s.cyc = 0; s.ins = 0;
        return s;
    endfunction

    function automatic mstate_t model_step(input mstate_t s);
        mstate_t     n;
        logic [11:0] a;
        logic [31:0] wd;
        logic        wr;
        n  = s;
        a  = bus.csr_waddr_i[11:0];
        wd = bus.csr_wdata_i;
        wr = bus.csr_we_i;
        if (trap_i) begin
            n.mepc = trap_pc_i & ~32'd3;
            n.mcause = trap_cause_i;
            n.mtval = trap_val_i;
            n.mpie = s.mie;
            n.mie = 0;
        end else if (mret_i) begin
            n.mie = s.mpie;
            n.mpie = 1;
        end else if (wr && a == 12'h300) begin
            n.mie = wd[3];
            n.mpie = wd[7];
        end
        if (wr) begin
            case (a)
                12'h304: n.ie = {wd[11], wd[7], wd[3]};
                12'h305: n.mtvec = wd & ~32'd3;
                12'h340: n.mscratch = wd;
                12'h341: if (!trap_i) n.mepc = wd & ~32'd3;
                12'h342: if (!trap_i) n.mcause = wd;
                12'h343: if (!trap_i) n.mtval = wd;
                default: ;
            endcase
        end
        n.cyc = s.cyc + 64'd1;
        n.ins = s.ins + (inst_retire_i ? 64'd1 : 64'd0);
        if (wr && a == 12'hB00) n.cyc = (s.cyc & 64'hFFFF_FFFF_0000_0000) | {32'd0, wd};
        if (wr && a == 12'hB80) n.cyc = (s.cyc & 64'h0000_0000_FFFF_FFFF) | {wd, 32'd0};
        if (wr && a == 12'hB02) n.ins = (s.ins & 64'hFFFF_FFFF_0000_0000) | {32'd0, wd};
        if (wr && a == 12'hB82) n.ins = (s.ins & 64'h0000_0000_FFFF_FFFF) | {wd, 32'd0};
        return n;
    endfunction

    function automatic logic [32:0] model_read(input mstate_t s, input logic [31:0] addr, input logic [2:0] irq);
        logic [31:0] d;
        logic        ill;
        d = 0; ill = 0;
        case (addr[11:0])
            12'h300: d = 32'h1800 + (s.mpie ? 32'h80 : 32'h0) + (s.mie ? 32'h8 : 32'h0);
            12'h301: d = TB_MISA;
            12'h304: d = (s.ie[2] ? 32'h800 : 0) + (s.ie[1] ? 32'h80 : 0) + (s.ie[0] ? 32'h8 : 0);
            12'h305: d = s.mtvec;
            12'h340: d = s.mscratch;
            12'h341: d = s.mepc;
            12'h342: d = s.mcause;
            12'h343: d = s.mtval;
            12'h344: d = (irq[2] ? 32'h800 : 0) + (irq[1] ? 32'h80 : 0) + (irq[0] ? 32'h8 : 0);
            12'hB00, 12'hC00: d = s.cyc[31:0];
            12'hB80, 12'hC80: d = s.cyc[63:32];
            12'hB02, 12'hC02: d = s.ins[31:0];
            12'hB82, 12'hC82: d = s.ins[63:32];
            12'hF14: d = TB_HART_ID;
            default: ill = 1;
        endcase
        return {ill, d};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m);
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] wa, wd, ra;
        logic        ret;
        logic [2:0]  irq;
        logic        trap;
        logic [31:0] pc, cause, val;
        logic        mret;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                                input logic [31:0] ra, input logic ret, input logic [2:0] irq,
                                input logic trap, input logic [31:0] pc, input logic [31:0] cause,
                                input logic [31:0] val, input logic mret,
                                input logic [31:0] exp, input logic ill);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.ret = ret; v.irq = irq;
        v.trap = trap; v.pc = pc; v.cause = cause; v.val = val; v.mret = mret;
        v.exp = exp; v.ill = ill;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.csr_we_i    = v.we;
        bus.csr_waddr_i = v.wa;
        bus.csr_wdata_i = v.wd;
        bus.csr_raddr_i = v.ra;
        inst_retire_i   = v.ret;
        irq_pending_i   = v.irq;
        trap_i          = v.trap;
        trap_pc_i       = v.pc;
        trap_cause_i    = v.cause;
        trap_val_i      = v.val;
        mret_i          = v.mret;
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    endtask

    logic [11:0] alist [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                                12'hC80, 12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h123};

    function automatic logic [31:0] rand_addr();
        logic [19:0] up;
        up = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0;
        return {up, alist[$urandom_range(0, 19)]};
    endfunction

    initial begin
        logic [32:0] mr;

        // Rows are consecutive cycles; expected read data is for the row's own cycle.
        //                we wa             wd            ra            rt irq     tr pc         cause          val         mr exp            ill
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h7C0,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h0,         1)); // 0
        tbl.push_back(mk(1, 32'h341,     32'h8000_0123,32'h341,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h0,         0)); // 1
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h341,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h8000_0120, 0)); // 2
        tbl.push_back(mk(1, 32'hB00,     32'hFFFF_FFFF,32'hB80,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h0,         0)); // 3
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hB00,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'hFFFF_FFFF, 0)); // 4
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hB00,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h0,         0)); // 5
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hB80,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h1,         0)); // 6
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hC80,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h1,         0)); // 7
        tbl.push_back(mk(1, 32'h300,     32'h8,        32'h300,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h1800,      0)); // 8
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h300,      0, 3'b000, 1, 32'h100,   32'h8000_000B, 32'hDEAD,   0, 32'h1808,      0)); // 9
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h341,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h100,       0)); // 10
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h342,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h8000_000B, 0)); // 11
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h300,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h1880,      0)); // 12
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h343,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      1, 32'hDEAD,      0)); // 13
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h300,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h1888,      0)); // 14
        tbl.push_back(mk(1, 32'h342,     32'h5,        32'h340,      0, 3'b000, 1, 32'h204,   32'h7,         32'h0,      0, 32'h0,         0)); // 15
        tbl.push_back(mk(1, 32'h340,     32'hA5,       32'h342,      0, 3'b000, 1, 32'h303,   32'h9,         32'h11,     0, 32'h7,         0)); // 16
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h340,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'hA5,        0)); // 17
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h341,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h300,       0)); // 18
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h300,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h1800,      0)); // 19
        tbl.push_back(mk(1, 32'h300,     32'h8,        32'h343,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      1, 32'h11,        0)); // 20
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h300,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h1880,      0)); // 21
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hB02,      1, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h0,         0)); // 22
        tbl.push_back(mk(1, 32'hB02,     32'h10,       32'hB02,      1, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h1,         0)); // 23
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hB02,      1, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h10,        0)); // 24
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hC02,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h11,        0)); // 25
        tbl.push_back(mk(1, 32'hC00,     32'h1234,     32'h305,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, TB_MTVEC_RST,  0)); // 26
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hB00,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h16,        0)); // 27
        tbl.push_back(mk(1, 32'h304,     32'hFFFF_FFFF,32'h304,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h0,         0)); // 28
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h304,      0, 3'b101, 0, 32'h0,     32'h0,         32'h0,      0, 32'h888,       0)); // 29
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h344,      0, 3'b101, 0, 32'h0,     32'h0,         32'h0,      0, 32'h808,       0)); // 30
        tbl.push_back(mk(1, 32'h305,     32'h2003,     32'h301,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, TB_MISA,       0)); // 31
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'h305,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h2000,      0)); // 32
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hF14,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, TB_HART_ID,    0)); // 33
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hABC0_0305,0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h2000,      0)); // 34
        tbl.push_back(mk(1, 32'h7C0,     32'h5,        32'h800,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h0,         1)); // 35
        tbl.push_back(mk(0, 32'h0,       32'h0,        32'hB82,      0, 3'b000, 0, 32'h0,     32'h0,         32'h0,      0, 32'h0,         0)); // 36

        // ---- reset state ----
        rst = 1'b1;
        idle_inputs();
        bus.csr_raddr_i = 32'h305;
        repeat (3) @(posedge clk);
        #1;
        check("reset read mtvec", bus.csr_rdata_o, TB_MTVEC_RST);
        check("reset mtvec_o", mtvec_o, TB_MTVEC_RST);
        check("reset mepc_o", mepc_o, 32'h0);
        check("reset mstatus_mie_o", 32'(mstatus_mie_o), 32'h0);
        check("reset mie_o", 32'(mie_o), 32'h0);
        bus.csr_raddr_i = 32'hB00;
        #1;
        check("reset mcycle", bus.csr_rdata_o, 32'h0);
        rst = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        bus.csr_raddr_i = 32'hB00;
        #4;
        check("mcycle after 5 idle", bus.csr_rdata_o, 32'd5);
        check("mcycle legal", 32'(bus.csr_illegal_o), 32'h0);
        @(posedge clk);
        #1;

        // ---- directed table ----
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #4;
            check($sformatf("row%0d rdata", i), bus.csr_rdata_o, tbl[i].exp);
            check($sformatf("row%0d illegal", i), 32'(bus.csr_illegal_o), 32'(tbl[i].ill));
            @(posedge clk);
            #1;
        end
        idle_inputs();
        #4;
        check("post-table mtvec_o", mtvec_o, 32'h2000);
        check("post-table mepc_o", mepc_o, 32'h300);
        check("post-table mie_o", 32'(mie_o), 32'h7);
        check("post-table mstatus_mie_o", 32'(mstatus_mie_o), 32'h0);
        @(posedge clk);
        #1;

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            bus.csr_we_i    = ($urandom_range(0, 1) == 1);
            bus.csr_waddr_i = rand_addr();
            bus.csr_wdata_i = $urandom;
            bus.csr_raddr_i = rand_addr();
            inst_retire_i   = ($urandom_range(0, 1) == 1);
            irq_pending_i   = 3'($urandom);
            trap_i          = ($urandom_range(0, 7) == 0);
            trap_pc_i       = $urandom;
            trap_cause_i    = $urandom;
            trap_val_i      = $urandom;
            mret_i          = ($urandom_range(0, 7) == 0);
            #4;
            mr = model_read(m, bus.csr_raddr_i, irq_pending_i);
            check($sformatf("rand%0d rdata @%h", i, bus.csr_raddr_i), bus.csr_rdata_o, mr[31:0]);
            check($sformatf("rand%0d illegal", i), 32'(bus.csr_illegal_o), 32'(mr[32]));
            check($sformatf("rand%0d mtvec_o", i), mtvec_o, m.mtvec);
            check($sformatf("rand%0d mepc_o", i), mepc_o, m.mepc);
            check($sformatf("rand%0d mstatus_mie_o", i), 32'(mstatus_mie_o), 32'(m.mie));
            check($sformatf("rand%0d mie_o", i), 32'(mie_o), 32'(m.ie));
            @(posedge clk);
            #1;
        end

        // ---- asynchronous reset mid-operation ----
        idle_inputs();
        bus.csr_raddr_i = 32'h340;
        #2;
        rst = 1'b1;
        #1;
        check("async rst mtvec_o", mtvec_o, TB_MTVEC_RST);
        check("async rst mepc_o", mepc_o, 32'h0);
        check("async rst mie_o", 32'(mie_o), 32'h0);
        check("async rst mstatus_mie_o", 32'(mstatus_mie_o), 32'h0);
        check("async rst mscratch", bus.csr_rdata_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.csr_raddr_i = 32'hB00;
        #1;
        check("mcycle restart", bus.csr_rdata_o, 32'd3);
        bus.csr_raddr_i = 32'hB82;
        #1;
        check("minstreth after rst", bus.csr_rdata_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
